// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus sequencer: state encoding and default phase timing.
package rtc_bus_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      A_SET = 3'd1,
      A_STB = 3'd2,
      A_HLD = 3'd3,
      D_SET = 3'd4,
      D_STB = 3'd5,
      D_HLD = 3'd6,
      DONE  = 3'd7
   } estado_t;

   localparam int T_SETUP_DEF = 2;
   localparam int T_PULSE_DEF = 4;
   localparam int T_HOLD_DEF  = 2;

   // A phase of N cycles loads N-1 so the counter reaches zero on the phase's last cycle.
   function automatic logic [7:0] carga(input int n);
      return 8'(n - 1);
   endfunction

endpackage

// File: rtl/rtc_fase_cnt.sv
// Loadable 8-bit phase down-counter; stops at zero and flags it on fin.
module rtc_fase_cnt (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] valor,
   output logic       fin
);

   logic [7:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= 8'd0;
      else if (load)
         cnt <= valor;
      else if (cnt != 8'd0)
         cnt <= cnt - 8'd1;
   end

   assign fin = (cnt == 8'd0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Multiplexed address/data bus-cycle sequencer for the external RTC; all outputs registered.
// Optional irq_rtc completion flag is built when RTC_IRQ_EN is defined.
import rtc_bus_pkg::*;

module rtc_bus_ctrl #(
   parameter int T_SETUP = T_SETUP_DEF,
   parameter int T_PULSE = T_PULSE_DEF,
   parameter int T_HOLD  = T_HOLD_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       actRTC,
   input  logic [7:0] dir,
   input  logic       wr_en,
   input  logic [7:0] dato_in,
   output logic [7:0] dato_out,
   output logic       listo,
   output logic       ocupado,
   output logic       rtc_cs_n,
   output logic       rtc_rd_n,
   output logic       rtc_wr_n,
   output logic       rtc_a_d,
   output logic [7:0] rtc_ad_out,
   output logic       rtc_ad_oe,
`ifdef RTC_IRQ_EN
   output logic       irq_rtc,
`endif
   input  logic [7:0] rtc_ad_in
);

   estado_t    estado, estado_nxt;
   logic       act_prev, acepta, fin, carga_en;
   logic [7:0] carga_val;
   logic       wr_q;
   logic [7:0] dir_q, dat_q, rd_q;
   logic       cs_n_c, rd_n_c, wr_n_c, a_d_c, oe_c, listo_c;
   logic [7:0] ad_c;

   assign acepta = (estado == IDLE) && actRTC && !act_prev;

   rtc_fase_cnt u_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (carga_en),
      .valor (carga_val),
      .fin   (fin)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado   <= IDLE;
         act_prev <= 1'b0;
      end else begin
         estado   <= estado_nxt;
         act_prev <= actRTC;
      end
   end

   always_comb begin
      estado_nxt = estado;
      carga_en   = 1'b0;
      carga_val  = 8'd0;
      case (estado)
         IDLE:  if (acepta) begin estado_nxt = A_SET; carga_en = 1'b1; carga_val = carga(T_SETUP); end
         A_SET: if (fin)    begin estado_nxt = A_STB; carga_en = 1'b1; carga_val = carga(T_PULSE); end
         A_STB: if (fin)    begin estado_nxt = A_HLD; carga_en = 1'b1; carga_val = carga(T_HOLD);  end
         A_HLD: if (fin)    begin estado_nxt = D_SET; carga_en = 1'b1; carga_val = carga(T_SETUP); end
         D_SET: if (fin)    begin estado_nxt = D_STB; carga_en = 1'b1; carga_val = carga(T_PULSE); end
         D_STB: if (fin)    begin estado_nxt = D_HLD; carga_en = 1'b1; carga_val = carga(T_HOLD);  end
         D_HLD: if (fin)    begin estado_nxt = DONE;  carga_en = 1'b1; carga_val = 8'd0;           end
         DONE:              begin estado_nxt = IDLE;  carga_en = 1'b1; carga_val = 8'd0;           end
         default:           estado_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dir_q <= 8'h00;
         dat_q <= 8'h00;
         wr_q  <= 1'b0;
         rd_q  <= 8'h00;
      end else begin
         if (acepta) begin
            dir_q <= dir;
            dat_q <= dato_in;
            wr_q  <= wr_en;
         end
         if (estado == D_STB && fin && !wr_q)
            rd_q <= rtc_ad_in;
      end
   end

   // Decoded from the next state so the pins change on the same edge as the state register.
   always_comb begin
      cs_n_c  = 1'b1;
      rd_n_c  = 1'b1;
      wr_n_c  = 1'b1;
      a_d_c   = 1'b0;
      oe_c    = 1'b0;
      listo_c = 1'b0;
      ad_c    = 8'h00;
      case (estado_nxt)
         A_SET, A_STB, A_HLD: begin
            cs_n_c = 1'b0;
            oe_c   = 1'b1;
            ad_c   = acepta ? dir : dir_q;
            wr_n_c = (estado_nxt != A_STB);
         end
         D_SET, D_STB, D_HLD: begin
            cs_n_c = 1'b0;
            a_d_c  = 1'b1;
            oe_c   = wr_q;
            ad_c   = wr_q ? dat_q : 8'h00;
            wr_n_c = !(estado_nxt == D_STB && wr_q);
            rd_n_c = !(estado_nxt == D_STB && !wr_q);
         end
         DONE:    listo_c = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rtc_cs_n   <= 1'b1;
         rtc_rd_n   <= 1'b1;
         rtc_wr_n   <= 1'b1;
         rtc_a_d    <= 1'b0;
         rtc_ad_oe  <= 1'b0;
         rtc_ad_out <= 8'h00;
         listo      <= 1'b0;
         ocupado    <= 1'b0;
         dato_out   <= 8'h00;
      end else begin
         rtc_cs_n   <= cs_n_c;
         rtc_rd_n   <= rd_n_c;
         rtc_wr_n   <= wr_n_c;
         rtc_a_d    <= a_d_c;
         rtc_ad_oe  <= oe_c;
         rtc_ad_out <= ad_c;
         listo      <= listo_c;
         ocupado    <= (estado_nxt != IDLE);
         if (estado_nxt == DONE && !wr_q)
            dato_out <= rd_q;
      end
   end

`ifdef RTC_IRQ_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         irq_rtc <= 1'b0;
      else if (estado_nxt == DONE)
         irq_rtc <= 1'b1;
      else if (acepta)
         irq_rtc <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Scoreboard bench for rtc_bus_ctrl: stimulus queues transactions, a negedge monitor checks pins per cycle.
module tb_rtc_bus_ctrl;

   localparam int S = 2;
   localparam int P = 4;
   localparam int H = 2;
   localparam int L = S + P + H;

   logic       clk = 1'b0;
   logic       reset;
   logic       actRTC;
   logic [7:0] dir, dato_in, rtc_ad_in;
   logic       wr_en;
   logic [7:0] dato_out, rtc_ad_out;
   logic       listo, ocupado, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_a_d, rtc_ad_oe;
`ifdef RTC_IRQ_EN
   logic       irq_rtc;
   logic       irq_exp = 1'b0;
`endif

   rtc_bus_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .actRTC     (actRTC),
      .dir        (dir),
      .wr_en      (wr_en),
      .dato_in    (dato_in),
      .dato_out   (dato_out),
      .listo      (listo),
      .ocupado    (ocupado),
      .rtc_cs_n   (rtc_cs_n),
      .rtc_rd_n   (rtc_rd_n),
      .rtc_wr_n   (rtc_wr_n),
      .rtc_a_d    (rtc_a_d),
      .rtc_ad_out (rtc_ad_out),
      .rtc_ad_oe  (rtc_ad_oe),
`ifdef RTC_IRQ_EN
      .irq_rtc    (irq_rtc),
`endif
      .rtc_ad_in  (rtc_ad_in)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      int         acc;
      logic       wr;
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] rb;
   } txn_t;

   txn_t       q[$];
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] last_dato = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: offset k from the accept cycle selects the bus phase.
   int         k, j;
   logic       dat, stb, done, w;
   logic [6:0] pins, ex;

   always @(negedge clk) begin
      pins = {rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_a_d, rtc_ad_oe, listo, ocupado};
      if (reset) begin
         chk("reset_pins", {1'b0, pins}, 8'h70);
         chk("reset_ad_out", rtc_ad_out, 8'h00);
         chk("reset_dato_out", dato_out, 8'h00);
`ifdef RTC_IRQ_EN
         irq_exp = 1'b0;
         chk("reset_irq", {7'd0, irq_rtc}, 8'h00);
`endif
      end else if (q.size() > 0 && cyc > q[0].acc) begin
         k    = cyc - q[0].acc;
         w    = q[0].wr;
         dat  = (k > L);
         j    = dat ? k - L : k;
         stb  = (j > S) && (j <= S + P);
         done = (k == 2 * L + 1);
         ex   = {done, !(stb && dat && !w), !(stb && (!dat || w)),
                 dat && !done, !done && (!dat || w), done, 1'b1};
         chk("bus_pins", {1'b0, pins}, {1'b0, ex});
         if (ex[2])
            chk("bus_ad_out", rtc_ad_out, dat ? q[0].d : q[0].a);
`ifdef RTC_IRQ_EN
         if (k == 1) irq_exp = 1'b0;
         if (done)   irq_exp = 1'b1;
         chk("irq_rtc", {7'd0, irq_rtc}, {7'd0, irq_exp});
`endif
         if (done || k > 2 * L + 1) begin
            if (!w) last_dato = q[0].rb;
            chk("dato_out_done", dato_out, last_dato);
            void'(q.pop_front());
         end
      end else begin
         chk("idle_pins", {1'b0, pins}, 8'h70);
         chk("idle_dato_out", dato_out, last_dato);
`ifdef RTC_IRQ_EN
         chk("idle_irq", {7'd0, irq_rtc}, {7'd0, irq_exp});
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      rtc_ad_in = 8'($urandom);
   endtask

   // mode 0: random actRTC chatter, 1: held high 40 cycles, 2: second pulse at cycle 8, 3: reset at cycle 12
   task automatic run_txn(input int mode, input logic wr, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] rb, input int gap);
      txn_t t;
      actRTC = 1'b0;
      repeat (gap + 1) step();
      actRTC  = 1'b1;
      dir     = a;
      wr_en   = wr;
      dato_in = d;
      t.acc = cyc; t.wr = wr; t.a = a; t.d = d; t.rb = rb;
      q.push_back(t);
      for (int kk = 1; kk <= 17; kk++) begin
         step();
         dir     = 8'($urandom);
         dato_in = 8'($urandom);
         wr_en   = 1'($urandom);
         if (kk == 14) rtc_ad_in = rb;
         case (mode)
            0:       actRTC = (kk < 17) ? 1'($urandom_range(0, 1)) : 1'b0;
            1:       actRTC = 1'b1;
            2:       actRTC = (kk == 8);
            default: actRTC = 1'b0;
         endcase
         if (mode == 3 && kk == 12) begin
            reset = 1'b1;
            q.delete();
            last_dato = 8'h00;
            #1;
            chk("async_reset", {4'd0, rtc_wr_n, rtc_cs_n, rtc_ad_oe, ocupado}, 8'h0C);
            chk("async_reset_listo", {7'd0, listo}, 8'h00);
            step();
            step();
            reset = 1'b0;
            return;
         end
      end
      if (mode == 1) begin
         repeat (23) step();
         actRTC = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      actRTC    = 1'b0;
      dir       = 8'h00;
      wr_en     = 1'b0;
      dato_in   = 8'h00;
      rtc_ad_in = 8'h00;
      repeat (3) step();
      reset = 1'b0;
      step();
      run_txn(0, 1'b1, 8'h21, 8'h45, 8'h00, 1);
      run_txn(0, 1'b0, 8'h42, 8'h00, 8'h37, 2);
      run_txn(1, 1'b1, 8'h10, 8'hA5, 8'h00, 0);
      run_txn(2, 1'b0, 8'h5A, 8'h00, 8'hC3, 1);
      run_txn(3, 1'b1, 8'h33, 8'h99, 8'h00, 0);
      run_txn(0, 1'b1, 8'h21, 8'h45, 8'h00, 1);
      run_txn(0, 1'b0, 8'h7F, 8'h00, 8'hE1, 0);
      for (int i = 0; i < 14; i++)
         run_txn(0, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3));
      repeat (5) step();
      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL pending_txn: got %0d outstanding, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
